// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared machine width and memory bus command encodings
package sys_defs;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

endpackage

// File: rtl/icache_mem.sv
// rtl/icache_mem.sv - direct-mapped tag/data/valid storage, async read, sync write
module icache_mem #(
  parameter int LINES = 32,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [63:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [63:0]      wr_data
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags  [LINES];
  logic [63:0]      lines [LINES];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = lines[rd_idx];

  // Only the valid bits need clearing; tag/data contents are don't-care while invalid.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      tags[wr_idx]  <= wr_tag;
      lines[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache with a single outstanding miss
module icache
  import sys_defs::*;
#(
  parameter int ICACHE_LINES = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] proc2Icache_addr,
  input  logic            proc2Icache_req,
  input  logic            squash,
  output logic [63:0]     Icache2proc_data,
  output logic            Icache2proc_valid,
  output bus_command_t    proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [31:0]     miss_count
);

  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = XLEN - 3 - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          state, next_state;
  logic [XLEN-1:0] miss_addr;
  logic [3:0]      mem_tag;
  logic            accept;
  logic            fill;
  logic            rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic            unused_addr_bits;

  assign req_idx          = proc2Icache_addr[3 +: IDX_W];
  assign req_tag          = proc2Icache_addr[XLEN-1:3+IDX_W];
  assign unused_addr_bits = ^proc2Icache_addr[2:0];

  assign Icache2proc_valid = proc2Icache_req && rd_valid && (rd_tag == req_tag);

  // Tag 0 means "no data", so a cleared latched tag can never complete a fill.
  assign fill = (state == S_WAIT) && (mem_tag != 4'd0) && (mem2proc_tag == mem_tag);

  icache_mem #(
    .LINES (ICACHE_LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_mem (
    .clock    (clock),
    .reset    (reset),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (Icache2proc_data),
    .wr_en    (fill),
    .wr_idx   (miss_addr[3 +: IDX_W]),
    .wr_tag   (miss_addr[XLEN-1:3+IDX_W]),
    .wr_data  (mem2proc_data)
  );

  always_comb begin
    next_state       = state;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    accept           = 1'b0;
    case (state)
      S_IDLE: begin
        if (proc2Icache_req && !Icache2proc_valid && !squash) begin
          next_state = S_REQ;
        end
      end
      S_REQ: begin
        if (squash) begin
          next_state = S_IDLE;
        end else begin
          proc2mem_command = BUS_LOAD;
          proc2mem_addr    = miss_addr;
          if (mem2proc_response != 4'd0) begin
            accept     = 1'b1;
            next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (fill) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      miss_addr  <= '0;
      mem_tag    <= 4'd0;
      miss_count <= 32'd0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && next_state == S_REQ) begin
        miss_addr <= {proc2Icache_addr[XLEN-1:3], 3'b000};
      end
      if (accept) begin
        mem_tag    <= mem2proc_response;
        miss_count <= miss_count + 32'd1;
      end else if (fill) begin
        mem_tag <= 4'd0;
      end
    end
  end

endmodule
